// File: rtl/valu_pipe.sv
// Multi-lane pipelined vector ALU: one opcode per beat (add or mul on all lanes), illegal ops flagged and counted.
// Latency: LAT cycles from accept to out_valid, one beat per cycle when out_ready stays high.
// Backpressure: a single global advance enable stalls every stage while out_valid & ~out_ready; in_ready drops then.
//
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready    input beat handshake; in_a/in_b are LANES packed operands, in_op the beat opcode
//   out_valid/out_ready  output beat handshake; out_res packed lane results, out_err illegal-op flag
//   err_cnt              saturating count of accepted illegal-op beats
module valu_pipe #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int LAT    = 2,
  parameter int OP_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_res,
  output logic                    out_err,
  output logic [15:0]             err_cnt
);

  localparam int VW = LANES * DATA_W;

  localparam logic [OP_W-1:0] OP_ADD_A = OP_W'(9'h000);
  localparam logic [OP_W-1:0] OP_ADD_B = OP_W'(9'h004);
  localparam logic [OP_W-1:0] OP_MUL_A = OP_W'(9'h0B9);
  localparam logic [OP_W-1:0] OP_MUL_B = OP_W'(9'h0BC);

  logic          adv;
  logic          accept;
  logic          is_add;
  logic          is_mul;
  logic          op_bad;
  logic [VW-1:0] dec_res;

  logic [LAT-1:0] stg_vld;
  logic [LAT-1:0] stg_err;
  logic [VW-1:0]  stg_res [LAT];

  // The whole pipe moves together; it only freezes when the output beat is not taken.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_add  = (in_op == OP_ADD_A) || (in_op == OP_ADD_B);
    is_mul  = (in_op == OP_MUL_A) || (in_op == OP_MUL_B);
    op_bad  = ~(is_add | is_mul);
    dec_res = '0;
    for (int i = 0; i < LANES; i++) begin
      if (is_add) begin
        dec_res[i*DATA_W +: DATA_W] = in_a[i*DATA_W +: DATA_W] + in_b[i*DATA_W +: DATA_W];
      end else if (is_mul) begin
        // DATA_W-wide context keeps only the low half of the product.
        dec_res[i*DATA_W +: DATA_W] = in_a[i*DATA_W +: DATA_W] * in_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
      stg_err <= '0;
      for (int k = 0; k < LAT; k++) begin
        stg_res[k] <= '0;
      end
      err_cnt <= '0;
    end else begin
      if (adv) begin
        stg_vld[0] <= accept;
        // Payload registers only load behind a valid beat, so bubbles never
        // disturb the held output data.
        if (accept) begin
          stg_err[0] <= op_bad;
          stg_res[0] <= dec_res;
        end
        for (int k = 1; k < LAT; k++) begin
          stg_vld[k] <= stg_vld[k-1];
          if (stg_vld[k-1]) begin
            stg_err[k] <= stg_err[k-1];
            stg_res[k] <= stg_res[k-1];
          end
        end
      end
      if (accept && op_bad && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign out_valid = stg_vld[LAT-1];
  assign out_err   = stg_err[LAT-1];
  assign out_res   = stg_res[LAT-1];

endmodule
